tcb_arb_2mp: RTL and testbench

Two-port TCB arbiter that merges two TCB managers, such as the CPU instruction and data ports, onto a single TCB manager port. That single port feeds the address decoder and peripheral fabric directly downstream. Arbitration and request forwarding are combinational. Grant locking and response-phase routing are registered, so a stalled transfer is never re-arbitrated and each delayed response reaches the manager that issued it.

---
 rtl/tcb_arb_2mp.sv | 137 +++++++++++++
 tb/tb_tcb_arb_2mp.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/tcb_arb_2mp.sv
// rtl/tcb_arb_2mp.sv - two-port TCB arbiter with grant lock and response routing
// Define TCB_ARB_RR_EN for round-robin arbitration; when it is undefined, port 0 always wins conflicts.
module tcb_arb_2mp #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int BW  = DW/8,
  parameter int DLY = 1
) (
  input  logic          clk,
  input  logic          rst,
  // subordinate port 0 (upstream manager 0)
  input  logic          sub0_vld,
  input  logic          sub0_wen,
  input  logic [BW-1:0] sub0_ben,
  input  logic [AW-1:0] sub0_adr,
  input  logic [DW-1:0] sub0_wdt,
  output logic          sub0_rdy,
  output logic [DW-1:0] sub0_rdt,
  output logic          sub0_err,
  // subordinate port 1 (upstream manager 1)
  input  logic          sub1_vld,
  input  logic          sub1_wen,
  input  logic [BW-1:0] sub1_ben,
  input  logic [AW-1:0] sub1_adr,
  input  logic [DW-1:0] sub1_wdt,
  output logic          sub1_rdy,
  output logic [DW-1:0] sub1_rdt,
  output logic          sub1_err,
  // manager port (downstream decoder)
  output logic          man_vld,
  output logic          man_wen,
  output logic [BW-1:0] man_ben,
  output logic [AW-1:0] man_adr,
  output logic [DW-1:0] man_wdt,
  input  logic          man_rdy,
  input  logic [DW-1:0] man_rdt,
  input  logic          man_err
);

  generate
    if (DLY < 0 || DLY > 4) begin : g_dly_check
      $error("tcb_arb_2mp: DLY must be within 0..4");
    end
  endgenerate

  logic lock;
  logic lock_idx;
  logic last;
  logic gnt;
  logic sel_vld;
  logic trn;
  logic rv;
  logic ri;

`ifdef TCB_ARB_RR_EN
  // Remember which port transferred most recently so the other one wins the next conflict.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last <= 1'b1;
    end else if (trn) begin
      last <= gnt;
    end
  end
`else
  // Fixed priority: act as if port 1 always went last, so port 0 wins every conflict.
  assign last = 1'b1;
`endif

  // Grant selection: a stalled transfer keeps its port, otherwise pick the requester.
  always_comb begin
    gnt = last;
    if (lock) begin
      gnt = lock_idx;
    end else if (sub0_vld ^ sub1_vld) begin
      gnt = sub1_vld;
    end else if (sub0_vld & sub1_vld) begin
      gnt = ~last;
    end
  end

  assign sel_vld  = gnt ? sub1_vld : sub0_vld;
  assign man_vld  = rst & sel_vld;
  assign man_wen  = gnt ? sub1_wen : sub0_wen;
  assign man_ben  = gnt ? sub1_ben : sub0_ben;
  assign man_adr  = gnt ? sub1_adr : sub0_adr;
  assign man_wdt  = gnt ? sub1_wdt : sub0_wdt;
  assign sub0_rdy = rst & ~gnt & man_rdy;
  assign sub1_rdy = rst &  gnt & man_rdy;
  assign trn      = man_vld & man_rdy;

  // Hold the grant while the downstream stalls; a dropped request releases it next cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lock     <= 1'b0;
      lock_idx <= 1'b0;
    end else begin
      lock <= man_vld & ~man_rdy;
      if (man_vld & ~man_rdy) begin
        lock_idx <= gnt;
      end
    end
  end

  generate
    if (DLY == 0) begin : g_rsp_comb
      assign rv = trn;
      assign ri = gnt;
    end else begin : g_rsp_pipe
      logic [DLY-1:0] rsp_vld;
      logic [DLY-1:0] rsp_idx;

      // Track which port owns each in-flight response so err returns to its issuer.
      always_ff @(posedge clk) begin
        if (!rst) begin
          rsp_vld <= '0;
          rsp_idx <= '0;
        end else begin
          rsp_vld[0] <= trn;
          rsp_idx[0] <= gnt;
          for (int i = 1; i < DLY; i++) begin
            rsp_vld[i] <= rsp_vld[i-1];
            rsp_idx[i] <= rsp_idx[i-1];
          end
        end
      end

      assign rv = rsp_vld[DLY-1];
      assign ri = rsp_idx[DLY-1];
    end
  endgenerate

  assign sub0_rdt = man_rdt;
  assign sub1_rdt = man_rdt;
  assign sub0_err = rst & man_err & rv & ~ri;
  assign sub1_err = rst & man_err & rv &  ri;

endmodule

// File: tb/tb_tcb_arb_2mp.sv
// tb/tb_tcb_arb_2mp.sv - directed and randomized bench for tcb_arb_2mp at DLY 0, 1 and 2
module tb_tcb_arb_2mp;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = 4;
  localparam int NCYC = 2048;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic          s0_vld, s0_wen, s1_vld, s1_wen;
  logic [BW-1:0] s0_ben, s1_ben;
  logic [AW-1:0] s0_adr, s1_adr;
  logic [DW-1:0] s0_wdt, s1_wdt;
  logic          m_rdy, m_err;
  logic [DW-1:0] m_rdt;

  logic          mv[3], mwen[3], r0[3], r1[3], e0[3], e1[3];
  logic [BW-1:0] mben[3];
  logic [AW-1:0] madr[3];
  logic [DW-1:0] mwdt[3], rdt0[3], rdt1[3];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int owner  = -1;
  int rr_prev = 1;
  int resp[3][NCYC];

  always #5 clk = ~clk;

  for (genvar d = 0; d < 3; d++) begin : g_dut
    tcb_arb_2mp #(.AW(AW), .DW(DW), .BW(BW), .DLY(d)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .sub0_vld (s0_vld),
      .sub0_wen (s0_wen),
      .sub0_ben (s0_ben),
      .sub0_adr (s0_adr),
      .sub0_wdt (s0_wdt),
      .sub0_rdy (r0[d]),
      .sub0_rdt (rdt0[d]),
      .sub0_err (e0[d]),
      .sub1_vld (s1_vld),
      .sub1_wen (s1_wen),
      .sub1_ben (s1_ben),
      .sub1_adr (s1_adr),
      .sub1_wdt (s1_wdt),
      .sub1_rdy (r1[d]),
      .sub1_rdt (rdt1[d]),
      .sub1_err (e1[d]),
      .man_vld  (mv[d]),
      .man_wen  (mwen[d]),
      .man_ben  (mben[d]),
      .man_adr  (madr[d]),
      .man_wdt  (mwdt[d]),
      .man_rdy  (m_rdy),
      .man_rdt  (m_rdt),
      .man_err  (m_err)
    );
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Winning port under the arbitration rules, -1 when nobody requests.
  function automatic int winner();
    if (owner >= 0) return owner;
    if (s0_vld && s1_vld) begin
`ifdef TCB_ARB_RR_EN
      return (rr_prev == 0) ? 1 : 0;
`else
      return 0;
`endif
    end
    if (s0_vld) return 0;
    if (s1_vld) return 1;
    return -1;
  endfunction

  task automatic step();
    int   g;
    logic gv;
    logic t;
    #1;
    if (!rst) begin
      for (int d = 0; d < 3; d++) begin
        check($sformatf("rst_d%0d_man_vld", d), mv[d], 1'b0);
        check($sformatf("rst_d%0d_rdy0", d), r0[d], 1'b0);
        check($sformatf("rst_d%0d_rdy1", d), r1[d], 1'b0);
        check($sformatf("rst_d%0d_err0", d), e0[d], 1'b0);
        check($sformatf("rst_d%0d_err1", d), e1[d], 1'b0);
        for (int k = 1; k <= 4; k++) resp[d][cyc+k] = 0;
      end
      owner   = -1;
      rr_prev = 1;
    end else begin
      g  = winner();
      gv = (g == 0) ? s0_vld : (g == 1) ? s1_vld : 1'b0;
      t  = gv && m_rdy;
      if (t) for (int d = 0; d < 3; d++) resp[d][cyc+d] = g + 1;
      for (int d = 0; d < 3; d++) begin
        check($sformatf("c%0d_d%0d_man_vld", cyc, d), mv[d], gv);
        if (gv) begin
          check($sformatf("c%0d_d%0d_man_adr", cyc, d), madr[d], (g == 1) ? s1_adr : s0_adr);
          check($sformatf("c%0d_d%0d_man_wdt", cyc, d), mwdt[d], (g == 1) ? s1_wdt : s0_wdt);
          check($sformatf("c%0d_d%0d_man_wen", cyc, d), mwen[d], (g == 1) ? s1_wen : s0_wen);
          check($sformatf("c%0d_d%0d_man_ben", cyc, d), mben[d], (g == 1) ? s1_ben : s0_ben);
          check($sformatf("c%0d_d%0d_rdy0", cyc, d), r0[d], (g == 0) && m_rdy);
          check($sformatf("c%0d_d%0d_rdy1", cyc, d), r1[d], (g == 1) && m_rdy);
        end
        check($sformatf("c%0d_d%0d_rdt0", cyc, d), rdt0[d], m_rdt);
        check($sformatf("c%0d_d%0d_rdt1", cyc, d), rdt1[d], m_rdt);
        check($sformatf("c%0d_d%0d_err0", cyc, d), e0[d], m_err && (resp[d][cyc] == 1));
        check($sformatf("c%0d_d%0d_err1", cyc, d), e1[d], m_err && (resp[d][cyc] == 2));
      end
      owner = (gv && !m_rdy) ? g : -1;
      if (t) rr_prev = g;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic set0(input logic v, input logic w, input logic [AW-1:0] a);
    s0_vld = v; s0_wen = w; s0_adr = a; s0_wdt = a ^ 32'h5A5A0000; s0_ben = a[3:0];
  endtask

  task automatic set1(input logic v, input logic w, input logic [AW-1:0] a);
    s1_vld = v; s1_wen = w; s1_adr = a; s1_wdt = a ^ 32'hA5A50000; s1_ben = ~a[3:0];
  endtask

  task automatic idle();
    set0(1'b0, 1'b0, '0);
    set1(1'b0, 1'b0, '0);
    m_rdy = 1'b1;
    m_err = 1'b0;
    m_rdt = $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 3; d++) for (int k = 0; k < NCYC; k++) resp[d][k] = 0;
    idle();
    @(negedge clk);

    // reset with requests pending: everything forced quiet
    set0(1'b1, 1'b0, 32'h10); set1(1'b1, 1'b1, 32'h20); m_err = 1'b1;
    step(); step();
    rst = 1'b1;

    // conflict alternation right after reset
    m_err = 1'b0;
    set0(1'b1, 1'b0, 32'h11); set1(1'b1, 1'b0, 32'h21);
    repeat (4) step();

    // single port read, data returned next cycle
    idle(); set0(1'b1, 1'b0, 32'h100); step();
    idle(); m_rdt = 32'hCAFE0001; step();

    // stall lock on port 1, port 0 arrives mid-stall
    idle(); m_rdy = 1'b0; set1(1'b1, 1'b1, 32'h200);
    repeat (3) step();
    set0(1'b1, 1'b0, 32'h300); step();
    m_rdy = 1'b1; step();
    set1(1'b0, 1'b0, '0); step();
    idle(); step();

    // error routing with two transfers in flight
    set0(1'b1, 1'b0, 32'h400); step();
    idle(); set1(1'b1, 1'b0, 32'h500); step();
    idle(); step();
    m_err = 1'b1; step();
    idle(); step();

    // zero-delay error on a port 1 write
    set1(1'b1, 1'b1, 32'h600); m_err = 1'b1; step();
    idle(); step(); step();

    // reset while a response is in flight, then a conflict
    set0(1'b1, 1'b0, 32'h700); m_err = 1'b1; step();
    rst = 1'b0; set0(1'b1, 1'b0, 32'h710); set1(1'b1, 1'b0, 32'h720); step();
    rst = 1'b1; step();
    idle(); step();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 49) != 0);
      set0($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom);
      set1($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom);
      m_rdy = ($urandom_range(0, 2) != 0);
      m_err = ($urandom_range(0, 1) == 1);
      m_rdt = $urandom;
      step();
    end
    rst = 1'b1; idle(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
